// File: rtl/snoop_bus_controller_pkg.sv
// ---------------------------------------------------------------------------
// snoop_bus_controller_pkg
//   Shared types and widths for the snooping coherence bus controller.
//   - bus_state_t : controller FSM states
//   - width_min1  : $clog2 that never returns 0 (counters/ids need >= 1 bit)
//   - *_DEF       : default geometry used by the top-level parameters
// ---------------------------------------------------------------------------
package snoop_bus_controller_pkg;

  localparam int NCORES_DEF    = 2;
  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int BLK_WORDS_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    C2C,
    MEM,
    WB
  } bus_state_t;

  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CORE_W_DEF = width_min1(NCORES_DEF);
  localparam int CNT_W_DEF  = width_min1(BLK_WORDS_DEF);

  typedef logic [CORE_W_DEF-1:0] core_id_t;

endpackage

// File: rtl/snoop_bus_controller_if.sv
// ---------------------------------------------------------------------------
// snoop_bus_controller_if
//   Bundles the per-core dcache handshake, the snoop signals and the single
//   RAM port.
//   modport slave  : the bus controller (consumes requests, drives RAM)
//   modport master : the environment (cores + RAM model)
// ---------------------------------------------------------------------------
interface snoop_bus_controller_if
  import snoop_bus_controller_pkg::*;
#(
  parameter int NCORES = NCORES_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // core -> controller
  logic [NCORES-1:0]             cctrans;
  logic [NCORES-1:0]             ccwrite;
  logic [NCORES-1:0]             dREN;
  logic [NCORES-1:0]             dWEN;
  logic [NCORES-1:0][ADDR_W-1:0] daddr;
  logic [NCORES-1:0][DATA_W-1:0] dstore;
  // controller -> core
  logic [NCORES-1:0]             dwait;
  logic [NCORES-1:0][DATA_W-1:0] dload;
  logic [NCORES-1:0]             ccwait;
  logic [NCORES-1:0]             ccinv;
  logic [NCORES-1:0][ADDR_W-1:0] ccsnoopaddr;
  // RAM port
  logic                          ram_ren;
  logic                          ram_wen;
  logic [ADDR_W-1:0]             ram_addr;
  logic [DATA_W-1:0]             ram_wdata;
  logic [DATA_W-1:0]             ram_rdata;
  logic                          ram_ready;
  // debug / perf
  logic                          c2c;

  modport slave (
    input  cctrans, ccwrite, dREN, dWEN, daddr, dstore, ram_rdata, ram_ready,
    output dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ram_ren, ram_wen, ram_addr, ram_wdata, c2c
  );

  modport master (
    output cctrans, ccwrite, dREN, dWEN, daddr, dstore, ram_rdata, ram_ready,
    input  dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ram_ren, ram_wen, ram_addr, ram_wdata, c2c
  );

endinterface

// File: rtl/snoop_bus_controller_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The search starts at ptr and wraps, so
//   the first requester at or after ptr wins. The pointer itself lives in
//   the top so both arbiter instances share one fairness pointer.
//   req      in  N     request vector
//   ptr      in  ID_W  highest-priority index this cycle
//   grant    out N     one-hot grant (all zero if no request)
//   grant_id out ID_W  index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter
  import snoop_bus_controller_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  always_comb begin : pick
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    grant    = '0;
    grant_id = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/snoop_bus_controller.sv
// ---------------------------------------------------------------------------
// snoop_bus_controller
//   Snooping coherence controller and RAM arbiter for NCORES L1 dcaches.
//   One transaction in flight: a coherence transaction (snoop, then either
//   an S->M upgrade, a cache-to-cache fill or a RAM fill) or a plain
//   writeback. Misses whose block is Modified in another cache are served
//   by that cache, with the same words written back to RAM in parallel.
//   CLK   in  clock
//   nRST  in  asynchronous active-low reset
//   bus   slave modport of snoop_bus_controller_if (core, snoop, RAM ports)
// ---------------------------------------------------------------------------
module snoop_bus_controller
  import snoop_bus_controller_pkg::*;
#(
  parameter int NCORES    = NCORES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BLK_WORDS = BLK_WORDS_DEF
) (
  input logic                   CLK,
  input logic                   nRST,
  snoop_bus_controller_if.slave bus
);

  localparam int ID_W   = width_min1(NCORES);
  localparam int WCNT_W = width_min1(BLK_WORDS);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BLK_WORDS - 1);

  bus_state_t        state_reg, state_next;
  logic [ID_W-1:0]   g_reg, g_next;        // granted requester
  logic [ID_W-1:0]   o_reg, o_next;        // Modified owner supplying a C2C fill
  logic              rdx_reg, rdx_next;    // exclusive intent -> invalidate snoopers
  logic              miss_reg, miss_next;  // fill needed (else upgrade only)
  logic [WCNT_W-1:0] cnt_reg, cnt_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;

  logic [NCORES-1:0] cc_grant, wb_grant;
  logic [ID_W-1:0]   cc_id, wb_id;
  logic [NCORES-1:0] peer;                 // every core except the granted one
  logic              owner_found;
  logic [ID_W-1:0]   owner_id;
  logic              snoop_drive, word_phase;

  logic [NCORES-1:0]             dwait, ccwait, ccinv;
  logic [NCORES-1:0][DATA_W-1:0] dload;
  logic [NCORES-1:0][ADDR_W-1:0] ccsnoopaddr;
  logic                          ram_ren, ram_wen, c2c;
  logic [ADDR_W-1:0]             ram_addr;
  logic [DATA_W-1:0]             ram_wdata;

  rr_arbiter #(.N(NCORES), .ID_W(ID_W)) u_cc_arb (
    .req(bus.cctrans), .ptr(ptr_reg), .grant(cc_grant), .grant_id(cc_id)
  );

  rr_arbiter #(.N(NCORES), .ID_W(ID_W)) u_wb_arb (
    .req(bus.dWEN), .ptr(ptr_reg), .grant(wb_grant), .grant_id(wb_id)
  );

  for (genvar gi = 0; gi < NCORES; gi++) begin : g_peer
    assign peer[gi] = (g_reg != ID_W'(gi));
  end

  // Lowest-index Modified holder wins if several claim ownership.
  always_comb begin
    owner_found = 1'b0;
    owner_id    = '0;
    for (int j = NCORES - 1; j >= 0; j--) begin
      if (peer[j] && bus.ccwrite[j]) begin
        owner_found = 1'b1;
        owner_id    = ID_W'(j);
      end
    end
  end

  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] id);
    return (id == ID_W'(NCORES - 1)) ? '0 : id + ID_W'(1);
  endfunction

  assign snoop_drive = (state_reg == SNOOP) || (state_reg == C2C) || (state_reg == MEM);
  assign word_phase  = (state_reg == C2C) || (state_reg == MEM) || (state_reg == WB);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      g_reg     <= '0;
      o_reg     <= '0;
      rdx_reg   <= 1'b0;
      miss_reg  <= 1'b0;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      o_reg     <= o_next;
      rdx_reg   <= rdx_next;
      miss_reg  <= miss_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    g_next      = g_reg;
    o_next      = o_reg;
    rdx_next    = rdx_reg;
    miss_next   = miss_reg;
    cnt_next    = cnt_reg;
    ptr_next    = ptr_reg;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    c2c         = 1'b0;

    // Snoopers stay stalled with the address presented for the whole
    // coherence transaction, not just the SNOOP cycle.
    if (snoop_drive) begin
      for (int j = 0; j < NCORES; j++) begin
        if (peer[j]) begin
          ccwait[j]      = 1'b1;
          ccinv[j]       = rdx_reg;
          ccsnoopaddr[j] = bus.daddr[g_reg];
        end
      end
    end

    unique case (state_reg)
      IDLE: begin
        // Coherence traffic always beats writebacks in the same cycle.
        if (|cc_grant) begin
          state_next = SNOOP;
          g_next     = cc_id;
          rdx_next   = |(bus.ccwrite & cc_grant);
          miss_next  = |(bus.dREN & cc_grant);
          ptr_next   = ptr_after(cc_id);
        end else if (|wb_grant) begin
          state_next = WB;
          g_next     = wb_id;
          rdx_next   = 1'b0;
          miss_next  = 1'b0;
          ptr_next   = ptr_after(wb_id);
        end
      end
      SNOOP: begin
        if (miss_reg) begin
          state_next = owner_found ? C2C : MEM;
          o_next     = owner_id;
        end else begin
          // S->M upgrade: the snoop invalidation is all that was needed.
          dwait[g_reg] = 1'b0;
          state_next   = IDLE;
        end
      end
      C2C: begin
        dload[g_reg] = bus.dstore[o_reg];
        ram_wen      = 1'b1;
        ram_addr     = bus.daddr[g_reg];
        ram_wdata    = bus.dstore[o_reg];
        c2c          = 1'b1;
        dwait[g_reg] = !bus.ram_ready;
        dwait[o_reg] = !bus.ram_ready;
      end
      MEM: begin
        ram_ren      = 1'b1;
        ram_addr     = bus.daddr[g_reg];
        dload[g_reg] = bus.ram_rdata;
        dwait[g_reg] = !bus.ram_ready;
      end
      WB: begin
        ram_wen      = 1'b1;
        ram_addr     = bus.daddr[g_reg];
        ram_wdata    = bus.dstore[g_reg];
        dwait[g_reg] = !bus.ram_ready;
      end
      default: state_next = IDLE;
    endcase

    // ram_ready outside a strobed word phase is ignored.
    if (word_phase && bus.ram_ready) begin
      if (cnt_reg == LAST_WORD) begin
        cnt_next   = '0;
        state_next = IDLE;
      end else begin
        cnt_next = cnt_reg + WCNT_W'(1);
      end
    end
  end

  assign bus.dwait       = dwait;
  assign bus.dload       = dload;
  assign bus.ccwait      = ccwait;
  assign bus.ccinv       = ccinv;
  assign bus.ccsnoopaddr = ccsnoopaddr;
  assign bus.ram_ren     = ram_ren;
  assign bus.ram_wen     = ram_wen;
  assign bus.ram_addr    = ram_addr;
  assign bus.ram_wdata   = ram_wdata;
  assign bus.c2c         = c2c;

endmodule

// File: tb/tb_snoop_bus_controller.sv
// ---------------------------------------------------------------------------
// tb_snoop_bus_controller
//   Self-checking bench: acts as the cores and the RAM, keeps a
//   transaction-level model (pending request sets, round-robin pointer,
//   memory contents) and checks the controller's outputs cycle by cycle.
// ---------------------------------------------------------------------------
module tb_snoop_bus_controller;
  import snoop_bus_controller_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 2;
  localparam int K_MEM = 0;
  localparam int K_C2C = 1;
  localparam int K_WB  = 2;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  snoop_bus_controller_if #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  snoop_bus_controller #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW), .BLK_WORDS(BW)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;
  int ptr_m   = 0;
  int round_id = 0;
  int wait_cnt = 0;
  int fixed_delay = -1;
  int wc[N];
  logic [AW-1:0] base[N];
  logic [DW-1:0] mem[logic [AW-1:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] core_data(input int j, input int w);
    return 32'hD000_0000 ^ DW'(j << 20) ^ DW'((round_id & 255) << 8) ^ DW'(w);
  endfunction

  function automatic int pick_delay();
    return (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
  endfunction

  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return 0;
  endfunction

  task automatic drive_cores();
    for (int j = 0; j < N; j++) begin
      bus.daddr[j]  = base[j] + AW'(4 * wc[j]);
      bus.dstore[j] = core_data(j, wc[j]);
    end
  endtask

  // RAM: completes a strobed word after a per-word delay; unstrobed cycles
  // sometimes raise a stray ram_ready, which the controller must ignore.
  task automatic ram_respond();
    if (bus.ram_ren || bus.ram_wen) begin
      if (wait_cnt == 0) begin
        bus.ram_ready = 1'b1;
        wait_cnt = pick_delay();
      end else begin
        bus.ram_ready = 1'b0;
        wait_cnt--;
      end
    end else begin
      bus.ram_ready = ($urandom_range(0, 3) == 0);
    end
    bus.ram_rdata = mem_rd(bus.ram_addr);
  endtask

  // Advance one clock: apply core updates after the edge, then answer RAM.
  task automatic step(input logic [N-1:0] acc, input logic [N-1:0] clr_req,
                      input logic [N-1:0] clr_wc);
    @(posedge CLK);
    #1;
    for (int j = 0; j < N; j++) begin
      if (acc[j]) wc[j]++;
      if (clr_wc[j]) wc[j] = 0;
      if (clr_req[j]) begin
        bus.cctrans[j] = 1'b0;
        bus.dWEN[j]    = 1'b0;
        bus.dREN[j]    = 1'b0;
      end
    end
    drive_cores();
    #1;
    ram_respond();
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs();
    check("rst_dwait", 64'(bus.dwait), 64'({N{1'b1}}));
    check("rst_ccwait", 64'(bus.ccwait), 64'(0));
    check("rst_ccinv", 64'(bus.ccinv), 64'(0));
    check("rst_strobes", 64'({bus.ram_ren, bus.ram_wen, bus.c2c}), 64'(0));
    check("rst_dload", 64'(bus.dload), 64'(0));
    check("rst_snoopaddr", 64'(bus.ccsnoopaddr), 64'(0));
    check("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
    check("rst_ram_wdata", 64'(bus.ram_wdata), 64'(0));
  endtask

  task automatic abort_and_reset();
    nRST = 1'b0;
    #1;
    check_reset_outputs();
    bus.cctrans = '0;
    bus.dWEN    = '0;
    bus.dREN    = '0;
    bus.ccwrite = '0;
    for (int j = 0; j < N; j++) wc[j] = 0;
    drive_cores();
    ptr_m = 0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  // One round: raise the given requests together and follow every
  // transaction the controller must serve until all are done.
  task automatic run_round(input logic [N-1:0] cc, input logic [N-1:0] wb,
                           input logic [N-1:0] wr, input logic [N-1:0] ren,
                           input int abort_word);
    logic [N-1:0] pend_cc, pend_wb, req, exp_dw, peers, acc, clr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic rdy, is_cc;
    int g, owner, kind, cyc;
    round_id++;
    for (int j = 0; j < N; j++) begin
      base[j] = AW'($urandom_range(0, 255) * BW * 4);
      wc[j] = 0;
    end
    bus.cctrans = cc;
    bus.dWEN    = wb & ~cc;
    bus.ccwrite = wr;
    bus.dREN    = cc & ren;
    drive_cores();
    wait_cnt = pick_delay();
    ram_respond();
    #1;
    pend_cc = cc;
    pend_wb = wb & ~cc;
    while ((pend_cc | pend_wb) != '0) begin
      is_cc = (pend_cc != '0);
      req   = is_cc ? pend_cc : pend_wb;
      g     = rr_pick(req, ptr_m);
      ptr_m = (g + 1) % N;
      peers = '1;
      peers[g] = 1'b0;
      // Grant cycle: controller still idle, drives nothing.
      check("idle_dwait", 64'(bus.dwait), 64'({N{1'b1}}));
      check("idle_ram", 64'({bus.ram_ren, bus.ram_wen}), 64'(0));
      check("idle_ccwait", 64'(bus.ccwait), 64'(0));
      step('0, '0, '0);
      owner = -1;
      kind  = K_WB;
      if (is_cc) begin
        for (int j = 0; j < N; j++) if (j != g && wr[j] && owner < 0) owner = j;
        exp_dw = '1;
        if (!ren[g]) exp_dw[g] = 1'b0;
        check("snoop_dwait", 64'(bus.dwait), 64'(exp_dw));
        check("snoop_ccwait", 64'(bus.ccwait), 64'(peers));
        check("snoop_ccinv", 64'(bus.ccinv), 64'(wr[g] ? peers : '0));
        check("snoop_ram", 64'({bus.ram_ren, bus.ram_wen}), 64'(0));
        for (int j = 0; j < N; j++)
          if (j != g) check("snoop_addr", 64'(bus.ccsnoopaddr[j]), 64'(base[g]));
        if (!ren[g]) begin
          $display("txn round=%0d core=%0d upgrade", round_id, g);
          step('0, N'(1) << g, N'(1) << g);
          pend_cc[g] = 1'b0;
          continue;
        end
        kind = (owner >= 0) ? K_C2C : K_MEM;
        step('0, '0, '0);
      end
      $display("txn round=%0d core=%0d kind=%s owner=%0d", round_id, g,
               (kind == K_MEM) ? "mem" : (kind == K_C2C) ? "c2c" : "wb", owner);
      for (int w = 0; w < BW; w++) begin
        cyc = 0;
        rdy = 1'b0;
        while (!rdy) begin
          if (kind == K_C2C && w == abort_word) begin
            abort_and_reset();
            return;
          end
          rdy = bus.ram_ready;
          a   = base[g] + AW'(4 * w);
          check("word_addr", 64'(bus.ram_addr), 64'(a));
          exp_dw = '1;
          if (rdy) begin
            exp_dw[g] = 1'b0;
            if (kind == K_C2C) exp_dw[owner] = 1'b0;
          end
          check("word_dwait", 64'(bus.dwait), 64'(exp_dw));
          check("word_c2c", 64'(bus.c2c), 64'(kind == K_C2C));
          if (kind == K_MEM) begin
            check("mem_strobe", 64'({bus.ram_ren, bus.ram_wen}), 64'(2'b10));
            if (rdy) check("mem_dload", 64'(bus.dload[g]), 64'(mem_rd(a)));
          end else begin
            d = (kind == K_C2C) ? core_data(owner, w) : core_data(g, w);
            check("wr_strobe", 64'({bus.ram_ren, bus.ram_wen}), 64'(2'b01));
            check("wr_wdata", 64'(bus.ram_wdata), 64'(d));
            if (kind == K_C2C) check("c2c_dload", 64'(bus.dload[g]), 64'(d));
            if (rdy) mem[a] = d;
          end
          if (is_cc) begin
            check("hold_ccwait", 64'(bus.ccwait), 64'(peers));
            check("hold_ccinv", 64'(bus.ccinv), 64'(wr[g] ? peers : '0));
          end
          acc = '0;
          clr = '0;
          if (rdy) begin
            acc[g] = 1'b1;
            if (kind == K_C2C) acc[owner] = 1'b1;
            if (w == BW - 1) clr = acc;
          end
          step(acc, (rdy && w == BW - 1) ? (N'(1) << g) : '0, clr);
          cyc++;
          if (!rdy && cyc > 20) begin
            n_total++;
            n_bad++;
            $display("FAIL word_timeout: got=%0d cycles exp<=20 core=%0d", cyc, g);
            abort_and_reset();
            return;
          end
        end
      end
      if (is_cc) pend_cc[g] = 1'b0;
      else pend_wb[g] = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] cc, wb, wr, ren;
    nRST = 1'b0;
    bus.cctrans   = '0;
    bus.ccwrite   = '0;
    bus.dREN      = '0;
    bus.dWEN      = '0;
    bus.ram_ready = 1'b0;
    bus.ram_rdata = '0;
    for (int j = 0; j < N; j++) begin
      base[j] = '0;
      wc[j] = 0;
    end
    drive_cores();
    repeat (3) @(negedge CLK);
    #1;
    check_reset_outputs();
    nRST = 1'b1;
    @(negedge CLK);

    // Core0 read miss, no owner, RAM ready immediately.
    fixed_delay = 0;
    run_round(2'b01, 2'b00, 2'b00, 2'b01, -1);
    // Core1 BusRdX, core0 holds the block Modified.
    run_round(2'b10, 2'b00, 2'b11, 2'b10, -1);
    // Simultaneous misses repeated: grants alternate 0,1,0,1.
    fixed_delay = -1;
    repeat (4) run_round(2'b11, 2'b00, 2'b00, 2'b11, -1);
    // Coherence beats writeback; then an upgrade.
    run_round(2'b01, 2'b10, 2'b00, 2'b01, -1);
    run_round(2'b01, 2'b00, 2'b01, 2'b00, -1);
    // Slow RAM: 3 wait cycles per word.
    fixed_delay = 3;
    run_round(2'b01, 2'b10, 2'b10, 2'b01, -1);
    // Reset during the second word of a C2C fill, then a clean restart.
    fixed_delay = 0;
    run_round(2'b10, 2'b00, 2'b01, 2'b10, 1);
    run_round(2'b11, 2'b00, 2'b00, 2'b11, -1);

    fixed_delay = -1;
    for (int r = 0; r < 40; r++) begin
      cc = '0;
      wb = '0;
      for (int j = 0; j < N; j++) begin
        case ($urandom_range(0, 2))
          1: cc[j] = 1'b1;
          2: wb[j] = 1'b1;
          default: ;
        endcase
      end
      if ((cc | wb) == '0) cc[0] = 1'b1;
      wr  = N'($urandom);
      ren = N'($urandom);
      run_round(cc, wb, wr, ren, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
